// File: rtl/ser_pkg.sv
// Shared types and helpers for the word serializer: FSM states, default widths
// and the byte-count clamp rule.
package ser_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } ser_state_e;

    // Requests of zero or beyond the word size fall back to a full word.
    function automatic int unsigned eff_count(input int unsigned nbytes,
                                              input int unsigned nmax);
        if (nbytes == 0 || nbytes > nmax) begin
            return nmax;
        end
        return nbytes;
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Word register with parallel load and one-byte shift in either direction;
// head_c_o is the byte that would leave next in the selected direction.
module byte_shift_reg
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              shift_left_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [BYTE_W-1:0] head_c_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end else if (shift_i) begin
            if (shift_left_i) begin
                data_q <= {data_q[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
            end else begin
                data_q <= {BYTE_W'(0), data_q[DATA_W-1:BYTE_W]};
            end
        end
    end

    assign head_c_o = shift_left_i ? data_q[DATA_W-1 -: BYTE_W] : data_q[BYTE_W-1:0];

endmodule

// File: rtl/word_serializer.sv
// Word-to-byte serializer feeding a byte FIFO with backpressure.
// Optional trailing XOR checksum byte when SER_CHECKSUM_EN is defined.
module word_serializer
    import ser_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned BYTE_W = DEF_BYTE_W,
    localparam int unsigned NBYTES = DATA_W / BYTE_W,
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  nbytes,
    input  logic              msb_first,
    input  logic              fifo_full,
    output logic [BYTE_W-1:0] out,
    output logic              req_wr,
    output logic              busy,
    output logic              done
);

    // Counter leaves room for the optional checksum strobe.
    localparam int unsigned SENT_W = $clog2(NBYTES + 2);
`ifdef SER_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    ser_state_e        state_q, state_d;
    logic              msb_q, msb_d;
    logic [SENT_W-1:0] tgt_q, tgt_d;
    logic [SENT_W-1:0] sent_q, sent_d;
    logic [BYTE_W-1:0] out_q, out_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sr_load_c, sr_shift_c;
    logic [BYTE_W-1:0] head_c;
`ifdef SER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    byte_shift_reg #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_shift (
        .clock        (clock),
        .reset        (reset),
        .load_i       (sr_load_c),
        .shift_i      (sr_shift_c),
        .shift_left_i (msb_q),
        .data_i       (data_in),
        .head_c_o     (head_c)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            msb_q   <= 1'b0;
            tgt_q   <= '0;
            sent_q  <= '0;
            out_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            msb_q   <= msb_d;
            tgt_q   <= tgt_d;
            sent_q  <= sent_d;
            out_q   <= out_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        msb_d      = msb_q;
        tgt_d      = tgt_q;
        sent_d     = sent_q;
        out_d      = out_q;
        req_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sr_load_c  = 1'b0;
        sr_shift_c = 1'b0;
`ifdef SER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_load_c = 1'b1;
                    msb_d     = msb_first;
                    tgt_d     = SENT_W'(eff_count(32'(nbytes), NBYTES) + EXTRA);
                    sent_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = SEND;
`ifdef SER_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            SEND: begin
                if (sent_q == tgt_q) begin
                    // Entering DONE raises done for exactly the DONE cycle.
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    sent_d  = '0;
                end else if (!fifo_full) begin
                    req_d  = 1'b1;
                    sent_d = sent_q + SENT_W'(1);
`ifdef SER_CHECKSUM_EN
                    if (sent_q == tgt_q - SENT_W'(1)) begin
                        out_d = csum_q;
                    end else begin
                        out_d      = head_c;
                        sr_shift_c = 1'b1;
                        csum_d     = csum_q ^ head_c;
                    end
`else
                    out_d      = head_c;
                    sr_shift_c = 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out    = out_q;
    assign req_wr = req_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed vector table, hand-written
// abort sequence and randomized transfers against a byte-list reference model.
module tb_word_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [2:0]  nbytes;
    logic        msb_first;
    logic        fifo_full;
    logic [7:0]  dout;
    logic        req_wr;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] data;
        logic [2:0]  nb;
        logic        msb;
        logic [31:0] fmask;
        bit          repulse;
        bit          start_at_done;
        int          exp_n;
        logic [31:0] exp_seq;
    } vec_t;

    word_serializer #(
        .DATA_W (32),
        .BYTE_W (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .nbytes    (nbytes),
        .msb_first (msb_first),
        .fifo_full (fifo_full),
        .out       (dout),
        .req_wr    (req_wr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic fbit(input logic [31:0] m, input int i);
        if (i < 0 || i > 31) return 1'b0;
        return m[i];
    endfunction

    // Reference: bytes in emission order, plus XOR byte when checksum is built in.
    task automatic model_bytes(input logic [31:0] d, input logic [2:0] nb, input logic msb);
        int n;
        logic [7:0] x;
        n = (nb == 3'd0 || nb > 3'd4) ? 4 : int'(nb);
        exp_q.delete();
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            int sh;
            logic [7:0] b;
            sh = msb ? 8 * (3 - i) : 8 * i;
            b  = 8'((d >> sh) & 32'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic table_bytes(input int n, input logic [31:0] seq);
        logic [7:0] x;
        exp_q.delete();
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(seq[31-8*i -: 8]);
            x = x ^ seq[31-8*i -: 8];
        end
`ifdef SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Drives one transfer; a byte is expected on every sample following a
    // cycle with fifo_full low, until all of exp_q is out; done one cycle later.
    task automatic run_xfer(input string tag, input logic [31:0] d, input logic [2:0] nb,
                            input logic msb, input logic [31:0] fmask,
                            input bit repulse, input bit start_at_done);
        int m;
        int issued;
        int last;
        bit exp_strobe;
        bit exp_done;
        m      = exp_q.size();
        issued = 0;
        last   = -1;
        @(negedge clock);
        start     = 1'b1;
        data_in   = d;
        nbytes    = nb;
        msb_first = msb;
        fifo_full = 1'b0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clock);
            exp_strobe = (j >= 1) && (issued < m) && !fbit(fmask, j - 1);
            check($sformatf("%s req_wr@%0d", tag, j), 32'(req_wr), 32'(exp_strobe));
            if (exp_strobe) begin
                check($sformatf("%s byte%0d", tag, issued), 32'(dout), 32'(exp_q[issued]));
                issued++;
                last = j;
            end else if (issued > 0) begin
                check($sformatf("%s hold@%0d", tag, j), 32'(dout), 32'(exp_q[issued-1]));
            end
            exp_done = (issued == m) && (last >= 0) && (j == last + 1);
            check($sformatf("%s done@%0d", tag, j), 32'(done), 32'(exp_done));
            check($sformatf("%s busy@%0d", tag, j), 32'(busy),
                  32'(!((issued == m) && (j > last))));
            start     = repulse && (j == 2);
            if (start) data_in = 32'h12345678;
            fifo_full = fbit(fmask, j);
            if (exp_done) begin
                if (start_at_done) begin
                    start   = 1'b1;
                    data_in = 32'hA5A5A5A5;
                end
                break;
            end
        end
        @(negedge clock);
        check({tag, " post req_wr"}, 32'(req_wr), 32'd0);
        check({tag, " post busy"},   32'(busy),   32'd0);
        check({tag, " post done"},   32'(done),   32'd0);
        start     = 1'b0;
        fifo_full = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int strobes;
        int dones;

        vecs[0] = '{32'hDEADBEEF, 3'd4, 1'b0, 32'h0,  1'b0, 1'b0, 4, 32'hEFBEADDE};
        vecs[1] = '{32'hDEADBEEF, 3'd4, 1'b1, 32'h0,  1'b0, 1'b0, 4, 32'hDEADBEEF};
        vecs[2] = '{32'hDEADBEEF, 3'd2, 1'b0, 32'h0,  1'b0, 1'b0, 2, 32'hEFBE0000};
        vecs[3] = '{32'hDEADBEEF, 3'd0, 1'b0, 32'h0,  1'b0, 1'b0, 4, 32'hEFBEADDE};
        vecs[4] = '{32'hDEADBEEF, 3'd7, 1'b0, 32'h0,  1'b0, 1'b0, 4, 32'hEFBEADDE};
        vecs[5] = '{32'hDEADBEEF, 3'd4, 1'b0, 32'h1C, 1'b0, 1'b0, 4, 32'hEFBEADDE};
        vecs[6] = '{32'hDEADBEEF, 3'd4, 1'b0, 32'h0,  1'b1, 1'b1, 4, 32'hEFBEADDE};
        vecs[7] = '{32'h01020304, 3'd4, 1'b0, 32'h0,  1'b0, 1'b0, 4, 32'h04030201};
        vecs[8] = '{32'h12345678, 3'd3, 1'b1, 32'h5,  1'b0, 1'b1, 3, 32'h12345600};
        vecs[9] = '{32'h12345678, 3'd1, 1'b0, 32'h3,  1'b1, 1'b0, 1, 32'h78000000};

        reset     = 1'b0;
        start     = 1'b0;
        data_in   = '0;
        nbytes    = '0;
        msb_first = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(negedge clock);
        check("reset out",    32'(dout),   32'd0);
        check("reset req_wr", 32'(req_wr), 32'd0);
        check("reset busy",   32'(busy),   32'd0);
        check("reset done",   32'(done),   32'd0);
        reset = 1'b1;

        for (int v = 0; v < 10; v++) begin
            table_bytes(vecs[v].exp_n, vecs[v].exp_seq);
            run_xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].nb, vecs[v].msb,
                     vecs[v].fmask, vecs[v].repulse, vecs[v].start_at_done);
        end

        // Reset after the second byte aborts the transfer with no done.
        @(negedge clock);
        start     = 1'b1;
        data_in   = 32'hDEADBEEF;
        nbytes    = 3'd4;
        msb_first = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("abort byte0", 32'(dout), 32'hEF);
        @(negedge clock);
        check("abort byte1", 32'(dout), 32'hBE);
        reset = 1'b0;
        @(negedge clock);
        check("abort out",    32'(dout),   32'd0);
        check("abort req_wr", 32'(req_wr), 32'd0);
        check("abort busy",   32'(busy),   32'd0);
        check("abort done",   32'(done),   32'd0);
        reset   = 1'b1;
        strobes = 0;
        dones   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            strobes += int'(req_wr);
            dones   += int'(done);
        end
        check("abort no strobes", 32'(strobes), 32'd0);
        check("abort no done",    32'(dones),   32'd0);

        for (int r = 0; r < 30; r++) begin
            logic [31:0] d;
            logic [2:0]  nb;
            logic        msb;
            logic [31:0] fm;
            d   = $urandom;
            nb  = 3'($urandom_range(0, 7));
            msb = 1'($urandom_range(0, 1));
            fm  = $urandom & $urandom;
            model_bytes(d, nb, msb);
            run_xfer($sformatf("rnd%0d", r), d, nb, msb, fm,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parametrised word-to-byte serializer for the RSA/RFID datapath. Captures one DATA_W-bit word on start and emits 1..NBYTES bytes as single-cycle write strobes into a downstream byte FIFO. Honours FIFO backpressure and supports runtime byte order and byte count. It is the generalised replacement for the fixed 32-bit, LSB-first, no-backpressure sender.

Parameters:
- DATA_W, 32, input word width; must be a multiple of BYTE_W.
- BYTE_W, 8, output symbol width.
- NBYTES, DATA_W/BYTE_W, derived; maximum bytes per word.
- CNT_W, $clog2(NBYTES+1), derived; byte counter width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low.
- start  in  1  capture data_in and begin transfer; sampled only in IDLE.
- data_in  in  DATA_W  word to send.
- nbytes  in  CNT_W  bytes to send; sampled with start.
- msb_first  in  1  0 = least-significant byte first, 1 = most-significant byte first; sampled with start.
- fifo_full  in  1  downstream FIFO full; no write is issued while high.
- out  out  BYTE_W  byte presented with req_wr.
- req_wr  out  1  one-cycle write strobe per byte.
- busy  out  1  high from the capture cycle until done.
- done  out  1  one-cycle pulse after the final byte.

Behaviour:
- Reset (reset==0 at an edge) forces: state IDLE, shift register 0, counter 0, out 0, req_wr 0, busy 0, done 0. Reset mid-transfer aborts the transfer: no further req_wr and no done.
- All outputs are registered.
- States: IDLE, SEND, DONE.
- IDLE:
  - start==1 → latch data_in, msb_first, and effective count N into registers; busy<=1; go to SEND.
  - N = nbytes when 1 ≤ nbytes ≤ NBYTES.
  - N = NBYTES when nbytes==0 or nbytes > NBYTES.
- SEND, per cycle:
  - If fifo_full==0 and sent<N: req_wr<=1, out<=current byte, sent<=sent+1, shift register advances by one byte.
  - Shift direction: right shift, taking bits [BYTE_W-1:0], when LSB-first; left shift, taking the top byte, when MSB-first. Vacated bits fill with 0.
  - If fifo_full==1: req_wr<=0; out, sent and shift register hold.
  - When sent reaches N, go to DONE.
- DONE: done<=1, busy<=0, req_wr<=0, counter cleared; return to IDLE next cycle.
- Timing:
  - start sampled at edge k → first req_wr visible after edge k+1.
  - With no backpressure, N bytes on N consecutive cycles; done one cycle after the last req_wr.
  - Each fifo_full cycle adds exactly one cycle of latency.
- start while busy is ignored (no re-latch, no queueing). start in the same cycle done is high is ignored, because the block is in DONE, not IDLE.
- out holds the last emitted byte between strobes; only the cycles with req_wr high carry meaning.
- fifo_full is sampled the same cycle req_wr would be registered. The FIFO must assert full with at least one free slot.

Optional Feature:
- Macro SER_CHECKSUM_EN.
- Defined: after the N payload bytes, one extra byte is emitted through the same handshake, obeying fifo_full like any payload byte. That byte is the XOR of all payload bytes sent. Total strobes = N+1, and done follows the checksum byte.
- Undefined: no checksum logic exists; exactly N strobes.

Decomposition:
- Package ser_pkg holds:
  - state enum (IDLE, SEND, DONE);
  - default BYTE_W and DATA_W localparams;
  - function eff_count(nbytes, NBYTES) implementing the clamp rule.
- One sub-module, byte_shift_reg: parametrised load / shift-left / shift-right register with hold enable. The checksum accumulator stays inline under the macro.

Test Plan:
- data_in=32'hDEADBEEF, nbytes=4, msb_first=0, fifo_full=0 → req_wr on 4 consecutive cycles with out = EF, BE, AD, DE; done one cycle later; busy high across the transfer.
- Same word with msb_first=1 → out = DE, AD, BE, EF.
- nbytes=2, LSB-first → out = EF, BE only. nbytes=0 and nbytes=7 → 4 bytes each, per the clamp rule.
- fifo_full held high for 3 cycles after the second byte → no req_wr during the stall; bytes 3 and 4 follow in order; done delayed by exactly 3 cycles.
- start re-pulsed mid-transfer with 32'h12345678 → ignored; original bytes complete. reset low after byte 2 → all outputs 0 next cycle and no done.
- SER_CHECKSUM_EN defined, data_in=32'h01020304, LSB-first → out = 04, 03, 02, 01, then 04 (the XOR); 5 strobes, then done.
